// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds
// and sticky overflow/underflow flags. Status flags are registered from next count.
module sync_fifo_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [WIDTH-1:0]  r_data_out;
   logic              r_full;
   logic              r_empty;
   logic              r_almost_full;
   logic              r_almost_empty;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [CNT_W-1:0]  w_count_nxt;

   // Acceptance is decided only from registered full/empty, never from the other request
   always_comb begin
      w_wr_ok     = we & ~r_full;
      w_rd_ok     = re & ~r_empty;
      w_count_nxt = r_count;
      if (w_wr_ok && !w_rd_ok) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   // Storage has no reset; contents after reset are don't-care
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= (CNT_W'(0) >= CNT_W'(AF_LEVEL));
         r_almost_empty <= (CNT_W'(0) <= CNT_W'(AE_LEVEL));
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty        <= (w_count_nxt == CNT_W'(0));
         r_almost_full  <= (w_count_nxt >= CNT_W'(AF_LEVEL));
         r_almost_empty <= (w_count_nxt <= CNT_W'(AE_LEVEL));
         if (we && r_full) begin
            r_overflow <= 1'b1;
         end
         if (re && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign data_out     = r_data_out;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (8 x 16, AF=14, AE=2).
module tb_sync_fifo_param;

   logic       clk;
   logic       rst;
   logic       we;
   logic       re;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int errors;
   int checks;

   sync_fifo_param #(
      .WIDTH(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in),
      .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; re = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b1; re = 1'b1; data_in = 8'hAA;
      tick();
      tick();
      rst = 1'b0; we = 1'b0; re = 1'b0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", almost_full); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", data_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", underflow); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; data_in = 8'(i);
         tick();
         checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
         checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 14)); end
         checks++; if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 15)); end
         checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
      end
      we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         re = 1'b1;
         tick();
         checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i)); end
         checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 15 - i); end
         checks++; if (empty !== (i == 15)) begin errors++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, empty, (i == 15)); end
         checks++; if (almost_empty !== (15 - i <= 2)) begin errors++; $display("FAIL drain_ae[%0d]: got %b expected %b", i, almost_empty, (15 - i <= 2)); end
      end
      re = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         we = 1'b1; data_in = 8'(8'h40 + i);
         tick();
         checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL wrap_w1_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      end
      we = 1'b0; re = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (data_out !== 8'(8'h40 + i)) begin errors++; $display("FAIL wrap_r1_data[%0d]: got %h expected %h", i, data_out, 8'(8'h40 + i)); end
         checks++; if (count !== 5'(9 - i)) begin errors++; $display("FAIL wrap_r1_count[%0d]: got %0d expected %0d", i, count, 9 - i); end
      end
      re = 1'b0;
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; data_in = 8'(8'h80 + i);
         tick();
         checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL wrap_w2_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      end
      we = 1'b0; re = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (data_out !== 8'(8'h80 + i)) begin errors++; $display("FAIL wrap_r2_data[%0d]: got %h expected %h", i, data_out, 8'(8'h80 + i)); end
         checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL wrap_r2_count[%0d]: got %0d expected %0d", i, count, 15 - i); end
      end
      re = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; data_in = 8'(8'h10 + i);
         tick();
      end
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_prefill: got %0d expected 5", count); end
      // Reads return the five prefilled words, then the words written during this run
      for (int k = 0; k < 20; k++) begin
         we = 1'b1; re = 1'b1; data_in = 8'(8'h20 + k);
         tick();
         checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 5", k, count); end
         checks++; if (data_out !== ((k < 5) ? 8'(8'h10 + k) : 8'(8'h20 + k - 5))) begin
            errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_out, (k < 5) ? 8'(8'h10 + k) : 8'(8'h20 + k - 5));
         end
      end
      we = 1'b0; re = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (data_out !== 8'(8'h2F + k)) begin errors++; $display("FAIL b2b_tail[%0d]: got %h expected %h", k, data_out, 8'(8'h2F + k)); end
      end
      // Empty: only the write lands, read flags underflow, data_out holds 0x33
      we = 1'b1; re = 1'b1; data_in = 8'h55;
      tick();
      we = 1'b0; re = 1'b0;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_empty_count: got %0d expected 1", count); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simul_empty_unf: got %b expected 1", underflow); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_empty_ovf: got %b expected 0", overflow); end
      checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL simul_empty_dout: got %h expected 33", data_out); end
      do_reset();
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; data_in = 8'(8'h60 + i);
         tick();
      end
      // Full: only the read lands, write flags overflow
      we = 1'b1; re = 1'b1; data_in = 8'h99;
      tick();
      we = 1'b0; re = 1'b0;
      checks++; if (count !== 5'd15) begin errors++; $display("FAIL simul_full_count: got %0d expected 15", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf: got %b expected 1", overflow); end
      checks++; if (data_out !== 8'h60) begin errors++; $display("FAIL simul_full_dout: got %h expected 60", data_out); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full_full: got %b expected 0", full); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL simul_full_unf: got %b expected 0", underflow); end
      do_reset();
   endtask

   task automatic test_errors();
      for (int i = 0; i < 17; i++) begin
         we = 1'b1; data_in = 8'(8'h70 + i);
         tick();
      end
      we = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_ovf: got %b expected 1", overflow); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL err_count16: got %0d expected 16", count); end
      re = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (data_out !== 8'(8'h70 + i)) begin errors++; $display("FAIL err_data[%0d]: got %h expected %h", i, data_out, 8'(8'h70 + i)); end
      end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL err_unf_early: got %b expected 0", underflow); end
      tick();
      re = 1'b0;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_unf: got %b expected 1", underflow); end
      checks++; if (data_out !== 8'h7F) begin errors++; $display("FAIL err_dout_hold: got %h expected 7f", data_out); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL err_count0: got %0d expected 0", count); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_ovf_sticky: got %b expected 1", overflow); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_unf_sticky: got %b expected 1", underflow); end
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_ovf_clr: got %b expected 0", overflow); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL err_unf_clr: got %b expected 0", underflow); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) begin
         we = 1'b1; data_in = 8'(8'hC0 + i);
         tick();
      end
      re = 1'b0;
      checks++; if (count !== 5'd9) begin errors++; $display("FAIL mid_count9: got %0d expected 9", count); end
      rst = 1'b1; we = 1'b1; data_in = 8'hEE;
      tick();
      rst = 1'b0; we = 1'b0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count0: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
      re = 1'b1;
      tick();
      re = 1'b0;
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_dout: got %h expected 00", data_out); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count_after_rd: got %0d expected 0", count); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mid_unf: got %b expected 1", underflow); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; we = 1'b0; re = 1'b0; data_in = 8'h00;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
